vrc_dac_tx: RTL and testbench
=============================

# vrc_dac_tx

Serial transmitter that delivers the two gain-control codes from the VRC curve generator to a dual-channel 10-bit SPI gain DAC. It watches `i_amp_one` and `i_amp_two`. When either code changes, or after a resync, it latches both codes and shifts two 16-bit frames out, channel one first. It then pulses the DAC load strobe so both gain stages update together. It sits between the VRC block and the analog front-end pins.

## Interface
- `CLK_DIV`, default 4: SCLK half-period in `clk` cycles; legal range 2..255.
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-high reset.
- `i_sync` input 1: resync strobe; forces a transfer even if codes are unchanged.
- `i_amp_one` input 10: gain code for DAC channel A.
- `i_amp_two` input 10: gain code for DAC channel B.
- `o_dac_sclk` output 1: SPI clock; idles low.
- `o_dac_cs_n` output 1: SPI chip select, active low.
- `o_dac_sdi` output 1: SPI data, MSB first.
- `o_dac_ldac_n` output 1: DAC load strobe, active low.
- `o_busy` output 1: high from LOAD_A through LDAC inclusive.
- `o_update_done` output 1: one-cycle pulse when LDAC ends.

## Operation
- Reset values:
  - `o_dac_sclk`=0, `o_dac_cs_n`=1, `o_dac_sdi`=0, `o_dac_ldac_n`=1, `o_busy`=0, `o_update_done`=0.
  - Last-sent registers = 0; `pending`=1, so the first update follows reset.
- Frame word, sent MSB first: `{chan, 1'b0, 2'b01, code[9:0], 2'b00}`.
  - `chan`=0 selects A, 1 selects B.
  - `2'b01` is normal mode.
- State machine:
  - IDLE → LOAD_A when `pending` is set, or `i_amp_one`/`i_amp_two` differ from the last-sent values.
  - In IDLE → LOAD_A, both inputs are latched into the shift source and the last-sent registers, and `pending` clears.
  - LOAD_A → SHIFT → GAP → LOAD_B → SHIFT → GAP → LDAC → IDLE.
- `i_sync` sets `pending` in any state. It never aborts a frame in progress.
- If `i_sync` arrives while busy, exactly one further update follows the current one.
- Input changes during a transfer are not sampled. They are compared again on the IDLE cycle after LDAC.
- If `i_sync` and a code change coincide in IDLE, one update starts, not two.

## Timing
D = `CLK_DIV`.
- LOAD (1 cycle):
  - `o_dac_cs_n`→0, `o_dac_sdi`=bit 15, SCLK low.
- SHIFT (32·D cycles): for each bit, SCLK low for D cycles, then high for D cycles.
  - SDI changes only on the `clk` edge where SCLK falls, or at LOAD.
  - The DAC samples on SCLK rise.
- GAP (D cycles): SCLK low, `o_dac_cs_n`=1, SDI=0.
- LDAC (D cycles): `o_dac_ldac_n`=0.
  - `o_update_done` pulses on the first IDLE cycle.
  - `o_busy` falls on that same cycle.
- Full update = 2 + 67·D cycles; 270 cycles for D=4.
- Latency from a code change, or `i_sync`, in IDLE to `cs_n` falling: 1 cycle.
- Back-to-back updates: at least one IDLE cycle separates them.
- Reset mid-frame:
  - All outputs return to their reset values immediately (asynchronous).
  - The partial frame is discarded; the DAC ignores it because CS rises.
  - `pending`=1 forces a full retransmit.

## Structure
- Package `vrc_dac_pkg` holds:
  - Frame width (16) and code width (10).
  - Mode bits `2'b01`.
  - Channel select constants.
  - State enum {IDLE, LOAD_A, LOAD_B, SHIFT, GAP, LDAC}.
  - A `chan_b` flag distinguishes the two passes through SHIFT and GAP.
- Sub-module `vrc_dac_bitclk`: D-cycle phase counter.
  - Produces `rise` and `fall` tick strobes.
  - Cleared on LOAD.
- Top level holds:
  - The FSM.
  - The 16-bit shift register.
  - A 5-bit bit counter.
  - The last-sent registers and the `pending` flag.

## Test plan
- Reset release with inputs A=10'h000 and B=10'h080, D=4:
  - Frame A word 16'h1000 and frame B word 16'h9200 are transmitted.
  - One LDAC pulse 4 cycles wide.
  - `o_update_done` fires 270 cycles after the start.
- Steady inputs for 1000 cycles after the first update → no CS activity.
- Change A 0x080→0x3FF mid-frame:
  - The current frames carry 0x080.
  - A second update carrying 0x3FF starts 1 cycle after `o_update_done`.
- `i_sync` pulses twice during a transfer with codes unchanged → exactly one extra update.
- `rst` asserted at bit 7 of frame B:
  - CS, SCLK and LDAC return to reset values in the same cycle.
  - After release, a full A+B update is sent.
- D=2 → 136-cycle update.
  - The SPI monitor confirms SDI is stable across every SCLK rise.

Source files
------------

// File: rtl/vrc_dac_pkg.sv
// Shared constants, state encoding and frame builder for the VRC gain-DAC transmitter.
package vrc_dac_pkg;

   localparam int         FRAME_W     = 16;
   localparam int         CODE_W      = 10;
   localparam logic [1:0] MODE_NORMAL = 2'b01;
   localparam logic       CHAN_A      = 1'b0;
   localparam logic       CHAN_B      = 1'b1;
   localparam logic [4:0] LAST_BIT    = 5'd15;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_A,
      LOAD_B,
      SHIFT,
      GAP,
      LDAC
   } state_t;

   // DAC command word: channel select, reserved zero, mode, code, two don't-care LSBs.
   function automatic logic [FRAME_W-1:0] make_frame(input logic chan,
                                                     input logic [CODE_W-1:0] code);
      return {chan, 1'b0, MODE_NORMAL, code, 2'b00};
   endfunction

endpackage

// File: rtl/vrc_dac_bitclk.sv
// SCLK phase counter: one period is 2*CLK_DIV clk cycles, low half first.
module vrc_dac_bitclk #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic rise,
   output logic fall,
   output logic high
);

   localparam logic [8:0] RISE_AT = 9'(CLK_DIV - 1);
   localparam logic [8:0] FALL_AT = 9'(2 * CLK_DIV - 1);

   logic [8:0] phase;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         phase <= '0;
      else if (clr || fall)
         phase <= '0;
      else
         phase <= phase + 9'd1;
   end

   // rise/fall flag the clk edge on which SCLK goes high/low.
   always_comb begin
      rise = !clr && (phase == RISE_AT);
      fall = !clr && (phase == FALL_AT);
      high = (phase > RISE_AT);
   end

endmodule

// File: rtl/vrc_dac_tx.sv
// Sends both VRC gain codes to a dual 10-bit SPI DAC whenever they change or on resync,
// then strobes LDAC so both channels update together.
module vrc_dac_tx
   import vrc_dac_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_sync,
   input  logic [CODE_W-1:0] i_amp_one,
   input  logic [CODE_W-1:0] i_amp_two,
   output logic              o_dac_sclk,
   output logic              o_dac_cs_n,
   output logic              o_dac_sdi,
   output logic              o_dac_ldac_n,
   output logic              o_busy,
   output logic              o_update_done
);

   state_t              state;
   state_t              state_nxt;
   logic                chan_b;
   logic                pending;
   logic                start;
   logic                clr;
   logic                rise;
   logic                fall;
   logic                high;
   logic                load_b;
   logic [FRAME_W-1:0]  sreg;
   logic [4:0]          bit_cnt;
   logic [CODE_W-1:0]   last_a;
   logic [CODE_W-1:0]   last_b;

   // i_sync is used directly so a resync in IDLE starts on the very next edge.
   assign start  = (state == IDLE) &&
                   (pending || i_sync || (i_amp_one != last_a) || (i_amp_two != last_b));
   assign clr    = (state == IDLE) || (state == LOAD_A) || (state == LOAD_B);
   assign load_b = (state == GAP) && rise && !chan_b;

   vrc_dac_bitclk #(
      .CLK_DIV (CLK_DIV)
   ) u_bitclk (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .rise (rise),
      .fall (fall),
      .high (high)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // GAP ends on the rise tick and LDAC on the following fall tick, so each lasts CLK_DIV.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:           if (start) state_nxt = LOAD_A;
         LOAD_A, LOAD_B: state_nxt = SHIFT;
         SHIFT:          if (fall && (bit_cnt == LAST_BIT)) state_nxt = GAP;
         GAP:            if (rise) state_nxt = chan_b ? LDAC : LOAD_B;
         LDAC:           if (fall) state_nxt = IDLE;
         default:        state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending       <= 1'b1;
         last_a        <= '0;
         last_b        <= '0;
         chan_b        <= CHAN_A;
         bit_cnt       <= '0;
         o_update_done <= 1'b0;
      end else begin
         pending       <= start ? 1'b0 : (pending | i_sync);
         o_update_done <= (state == LDAC) && fall;
         if (start) begin
            last_a <= i_amp_one;
            last_b <= i_amp_two;
            chan_b <= CHAN_A;
         end else if (load_b) begin
            chan_b <= CHAN_B;
         end
         if ((state == SHIFT) && fall)
            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 5'd1;
      end
   end

   // SDI only moves on the SCLK falling edge, leaving a full half-period of setup.
   always_ff @(posedge clk) begin
      if (start)
         sreg <= make_frame(CHAN_A, i_amp_one);
      else if (load_b)
         sreg <= make_frame(CHAN_B, last_b);
      else if ((state == SHIFT) && fall)
         sreg <= {sreg[FRAME_W-2:0], 1'b0};
   end

   always_comb begin
      o_dac_sclk   = 1'b0;
      o_dac_cs_n   = 1'b1;
      o_dac_sdi    = 1'b0;
      o_dac_ldac_n = 1'b1;
      o_busy       = 1'b1;
      case (state)
         IDLE:           o_busy = 1'b0;
         LOAD_A, LOAD_B: begin
            o_dac_cs_n = 1'b0;
            o_dac_sdi  = sreg[FRAME_W-1];
         end
         SHIFT: begin
            o_dac_cs_n = 1'b0;
            o_dac_sdi  = sreg[FRAME_W-1];
            o_dac_sclk = high;
         end
         LDAC:           o_dac_ldac_n = 1'b0;
         default:        ;
      endcase
   end

endmodule

// File: tb/tb_vrc_dac_tx.sv
// Directed bench for vrc_dac_tx: SPI monitor feeds a frame scoreboard; D=4 and D=2 instances.
module tb_vrc_dac_tx;

   logic       clk = 1'b0;
   logic       rst0 = 1'b1;
   logic       rst1 = 1'b1;
   logic       sync = 1'b0;
   logic [9:0] amp_one = 10'h000;
   logic [9:0] amp_two = 10'h080;
   logic       sel = 1'b0;

   logic sclk0, cs_n0, sdi0, ldac_n0, busy0, done0;
   logic sclk1, cs_n1, sdi1, ldac_n1, busy1, done1;
   logic m_sclk, m_cs_n, m_sdi, m_ldac_n, m_busy, m_done, m_rst;

   int n_tests = 0;
   int n_fail  = 0;
   int cur_d   = 4;

   logic [15:0] exp_q[$];
   logic [15:0] rx_mem [64];
   int          rx_len [64];
   int          wr_idx = 0;
   int          rd_idx = 0;

   int          nbits = 0, unstable = 0, ldac_cnt = 0, ldac_w = 0;
   int          ldac_pulses = 0, cs_falls = 0;
   logic [15:0] shreg = '0;
   logic        prev_sclk = 1'b0, prev_cs = 1'b1, prev_sdi = 1'b0, prev_ldac = 1'b1;

   always #5 clk = ~clk;

   vrc_dac_tx #(.CLK_DIV(4)) dut4 (
      .clk (clk), .rst (rst0), .i_sync (sync),
      .i_amp_one (amp_one), .i_amp_two (amp_two),
      .o_dac_sclk (sclk0), .o_dac_cs_n (cs_n0), .o_dac_sdi (sdi0),
      .o_dac_ldac_n (ldac_n0), .o_busy (busy0), .o_update_done (done0)
   );

   vrc_dac_tx #(.CLK_DIV(2)) dut2 (
      .clk (clk), .rst (rst1), .i_sync (sync),
      .i_amp_one (amp_one), .i_amp_two (amp_two),
      .o_dac_sclk (sclk1), .o_dac_cs_n (cs_n1), .o_dac_sdi (sdi1),
      .o_dac_ldac_n (ldac_n1), .o_busy (busy1), .o_update_done (done1)
   );

   assign m_sclk   = sel ? sclk1   : sclk0;
   assign m_cs_n   = sel ? cs_n1   : cs_n0;
   assign m_sdi    = sel ? sdi1    : sdi0;
   assign m_ldac_n = sel ? ldac_n1 : ldac_n0;
   assign m_busy   = sel ? busy1   : busy0;
   assign m_done   = sel ? done1   : done0;
   assign m_rst    = sel ? rst1    : rst0;

   // SPI monitor: captures bits on SCLK rise, stores a frame when CS rises.
   always @(negedge clk) begin
      prev_sclk <= m_sclk;
      prev_cs   <= m_cs_n;
      prev_sdi  <= m_sdi;
      prev_ldac <= m_ldac_n;
      if (m_rst) begin
         nbits    <= 0;
         ldac_cnt <= 0;
      end else begin
         if (!m_cs_n && m_sclk && !prev_sclk) begin
            shreg <= {shreg[14:0], m_sdi};
            nbits <= nbits + 1;
            if (m_sdi !== prev_sdi) unstable <= unstable + 1;
         end
         if (!m_cs_n && prev_cs) cs_falls <= cs_falls + 1;
         if (m_cs_n && !prev_cs) begin
            rx_mem[wr_idx % 64] <= shreg;
            rx_len[wr_idx % 64] <= nbits;
            wr_idx <= wr_idx + 1;
            nbits  <= 0;
         end
         if (!m_ldac_n) ldac_cnt <= ldac_cnt + 1;
         if (m_ldac_n && !prev_ldac) begin
            ldac_w      <= ldac_cnt;
            ldac_pulses <= ldac_pulses + 1;
            ldac_cnt    <= 0;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_tests++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   function automatic logic [15:0] frame(input logic ch, input logic [9:0] code);
      return {ch, 3'b001, code, 2'b00};
   endfunction

   task automatic expect_update(input logic [9:0] a, input logic [9:0] b);
      exp_q.push_back(frame(1'b0, a));
      exp_q.push_back(frame(1'b1, b));
   endtask

   task automatic check_frames();
      logic [15:0] want;
      while (rd_idx < wr_idx) begin
         chk("frame_expected", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            chk("frame_word", 32'(rx_mem[rd_idx % 64]), 32'(want));
            chk("frame_bits", rx_len[rd_idx % 64], 16);
         end
         rd_idx++;
      end
   endtask

   task automatic wait_start(output int lat);
      lat = 0;
      do begin
         tick();
         lat++;
      end while (m_cs_n !== 1'b0 && lat < 2000);
      chk("cs_fall_seen", 32'(m_cs_n), 0);
   endtask

   task automatic wait_done(output int len);
      len = 0;
      while (m_done !== 1'b1 && len < 2000) begin
         tick();
         len++;
      end
      chk("done_seen", 32'(m_done), 1);
      chk("busy_low_at_done", 32'(m_busy), 0);
      chk("ldac_width", ldac_w, cur_d);
   endtask

   initial begin
      int lat, len, base_cs, base_ldac, w0;

      // Reset values
      repeat (2) tick();
      chk("rst_sclk",   32'(m_sclk),   0);
      chk("rst_cs_n",   32'(m_cs_n),   1);
      chk("rst_sdi",    32'(m_sdi),    0);
      chk("rst_ldac_n", 32'(m_ldac_n), 1);
      chk("rst_busy",   32'(m_busy),   0);
      chk("rst_done",   32'(m_done),   0);

      // First update after reset release: A=000, B=080
      exp_q.push_back(16'h1000);
      exp_q.push_back(16'h9200);
      base_ldac = ldac_pulses;
      rst0 = 1'b0;
      wait_start(lat);
      chk("first_latency", lat, 1);
      chk("busy_at_load", 32'(m_busy), 1);
      wait_done(len);
      chk("first_update_len", len, 270);
      tick();
      chk("done_one_cycle", 32'(m_done), 0);
      chk("ldac_pulse_count", ldac_pulses - base_ldac, 1);
      check_frames();
      chk("sb_empty_first", exp_q.size(), 0);

      // Steady inputs: no CS activity
      base_cs = cs_falls;
      repeat (1000) tick();
      chk("steady_no_cs", cs_falls - base_cs, 0);

      // Code change, then a second change mid-frame
      amp_one = 10'h080;
      expect_update(10'h080, 10'h080);
      wait_start(lat);
      chk("change_latency", lat, 1);
      repeat (50) tick();
      amp_one = 10'h3FF;
      expect_update(10'h3FF, 10'h080);
      wait_done(len);
      tick();
      chk("restart_after_done", 32'(m_cs_n), 0);
      wait_done(len);
      chk("second_update_len", len, 270);
      check_frames();
      chk("sb_empty_change", exp_q.size(), 0);

      // Resync, then two more resyncs during the transfer: exactly one extra update
      base_cs = cs_falls;
      sync = 1'b1;
      expect_update(10'h3FF, 10'h080);
      wait_start(lat);
      sync = 1'b0;
      chk("sync_latency", lat, 1);
      repeat (30) tick();
      sync = 1'b1;
      tick();
      sync = 1'b0;
      repeat (100) tick();
      sync = 1'b1;
      tick();
      sync = 1'b0;
      expect_update(10'h3FF, 10'h080);
      wait_done(len);
      tick();
      chk("sync_extra_start", 32'(m_cs_n), 0);
      wait_done(len);
      chk("sync_extra_len", len, 270);
      repeat (600) tick();
      chk("sync_update_count", cs_falls - base_cs, 4);
      check_frames();
      chk("sb_empty_sync", exp_q.size(), 0);

      // Resync coinciding with a code change in IDLE: one update
      base_cs = cs_falls;
      amp_two = 10'h155;
      sync = 1'b1;
      expect_update(10'h3FF, 10'h155);
      wait_start(lat);
      sync = 1'b0;
      chk("coincide_latency", lat, 1);
      wait_done(len);
      repeat (400) tick();
      chk("coincide_single", cs_falls - base_cs, 2);
      check_frames();
      chk("sb_empty_coincide", exp_q.size(), 0);

      // Reset at bit 7 of frame B, then full retransmit
      sync = 1'b1;
      expect_update(10'h3FF, 10'h155);
      tick();
      sync = 1'b0;
      w0 = wr_idx;
      len = 0;
      while (!(wr_idx > w0 && m_cs_n === 1'b0 && nbits == 7) && len < 2000) begin
         tick();
         len++;
      end
      chk("reached_frame_b_bit7", 32'(len < 2000), 1);
      rst0 = 1'b1;
      #1;
      chk("midrst_cs_n",   32'(m_cs_n),   1);
      chk("midrst_sclk",   32'(m_sclk),   0);
      chk("midrst_ldac_n", 32'(m_ldac_n), 1);
      chk("midrst_sdi",    32'(m_sdi),    0);
      chk("midrst_busy",   32'(m_busy),   0);
      repeat (3) tick();
      check_frames();
      exp_q.delete();
      rst0 = 1'b0;
      expect_update(10'h3FF, 10'h155);
      wait_start(lat);
      chk("retx_latency", lat, 1);
      wait_done(len);
      chk("retx_len", len, 270);
      check_frames();
      chk("sb_empty_retx", exp_q.size(), 0);

      // CLK_DIV = 2 instance
      sel = 1'b1;
      cur_d = 2;
      tick();
      rst1 = 1'b0;
      expect_update(10'h3FF, 10'h155);
      wait_start(lat);
      chk("d2_latency", lat, 1);
      wait_done(len);
      chk("d2_update_len", len, 136);
      check_frames();

      chk("sdi_stable_at_rise", unstable, 0);
      chk("sb_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
